score_seg_encoder: RTL and testbench

Produces the segment pattern that the seven-segment multiplexer drives for whichever digit it currently selects. It takes a binary score, converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine, and returns the active-low segment code for the digit index `di` supplied by the display driver. Leading zeros are blanked. The block sits between the game's score register and the display driver.

---
 rtl/score_seg_encoder.sv | 140 ++++++++++++++
 tb/tb_score_seg_encoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/score_seg_encoder.sv
// Binary score to four BCD digits (serial double-dabble), then registered
// active-low seven-segment code for the digit picked by the display driver.
module score_seg_encoder #(
  parameter int SCORE_W       = 14,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SCORE_W-1:0] score,
  input  logic               load,
  output logic               busy,
  output logic               done,
  output logic [15:0]        bcd,
  input  logic [1:0]         di,
  output logic [6:0]         seg,
  output logic               dp
);

  typedef enum logic [1:0] {IDLE, SHIFT, PUBLISH} state_t;

  localparam int                 CNT_W   = (SCORE_W > 2) ? $clog2(SCORE_W) : 1;
  localparam logic [CNT_W-1:0]   CNT_END = CNT_W'(SCORE_W - 1);
  localparam logic [SCORE_W-1:0] SAT_VAL = SCORE_W'(9999);

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [SCORE_W-1:0] bin_reg;
  logic [15:0]        work_reg;
  logic [15:0]        bcd_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [6:0]         seg_reg;

  logic [15:0]        adj_next;
  logic [SCORE_W-1:0] cap_next;
  logic [3:0]         blank_next;
  logic [3:0]         nib_next;
  logic [6:0]         seg_next;

  // Add-3 correction of every working nibble before the shift.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_adj
      assign adj_next[4*gi +: 4] = (work_reg[4*gi +: 4] >= 4'd5) ?
                                   (work_reg[4*gi +: 4] + 4'd3) :
                                   work_reg[4*gi +: 4];
    end
  endgenerate

  // Scores above the four-digit range are clamped so the display reads 9999.
  assign cap_next = (32'(score) > 32'd9999) ? SAT_VAL : score;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bin_reg   <= '0;
      work_reg  <= '0;
      bcd_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (load) begin
            bin_reg   <= cap_next;
            work_reg  <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          work_reg <= {adj_next[14:0], bin_reg[SCORE_W-1]};
          bin_reg  <= {bin_reg[SCORE_W-2:0], 1'b0};
          if (cnt_reg == CNT_END) begin
            state_reg <= PUBLISH;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        PUBLISH: begin
          // Single-step publish keeps partial results off the display.
          bcd_reg   <= work_reg;
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Digit d is blank when it and every more significant digit are zero.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_blank
      if (gi == 0 || !BLANK_LEADING) begin : g_never
        assign blank_next[gi] = 1'b0;
      end else begin : g_lead
        assign blank_next[gi] = ~|bcd_reg[15:4*gi];
      end
    end
  endgenerate

  always_comb begin
    nib_next = bcd_reg[{di, 2'b00} +: 4];
    seg_next = 7'h7F;
    if (!blank_next[di]) begin
      case (nib_next)
        4'd0:    seg_next = 7'h40;
        4'd1:    seg_next = 7'h79;
        4'd2:    seg_next = 7'h24;
        4'd3:    seg_next = 7'h30;
        4'd4:    seg_next = 7'h19;
        4'd5:    seg_next = 7'h12;
        4'd6:    seg_next = 7'h02;
        4'd7:    seg_next = 7'h78;
        4'd8:    seg_next = 7'h00;
        4'd9:    seg_next = 7'h10;
        default: seg_next = 7'h7F;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_reg <= 7'h7F;
    end else begin
      seg_reg <= seg_next;
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign bcd  = bcd_reg;
  assign seg  = seg_reg;
  assign dp   = 1'b1;

endmodule

// File: tb/tb_score_seg_encoder.sv
// Directed bench for score_seg_encoder: decimal-arithmetic reference model
// checked every cycle, plus literal expectations from worked examples.
module tb_score_seg_encoder;
  localparam int SW = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [SW-1:0] score = '0;
  logic [1:0]    di = 2'd0;
  logic          busy, done, dp, busy_nb, done_nb, dp_nb;
  logic [15:0]   bcd, bcd_nb;
  logic [6:0]    seg, seg_nb;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  score_seg_encoder #(.SCORE_W(SW), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .rst(rst), .score(score), .load(load), .busy(busy),
    .done(done), .bcd(bcd), .di(di), .seg(seg), .dp(dp)
  );

  score_seg_encoder #(.SCORE_W(SW), .BLANK_LEADING(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .score(score), .load(load), .busy(busy_nb),
    .done(done_nb), .bcd(bcd_nb), .di(di), .seg(seg_nb), .dp(dp_nb)
  );

  function automatic logic [6:0] seg_code(int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] enc(int val, int d, bit blank);
    int p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    if (blank && d > 0 && val < p) return 7'h7F;
    return seg_code((val / p) % 10);
  endfunction

  function automatic logic [15:0] to_bcd(int val);
    return {4'((val / 1000) % 10), 4'((val / 100) % 10),
            4'((val / 10) % 10), 4'(val % 10)};
  endfunction

  // Reference model: decimal value, countdown to publish, registered segment.
  int         m_val = 0, m_target = 0, m_left = 0;
  bit         m_done = 0;
  logic [6:0] m_seg = 7'h7F, m_seg_nb = 7'h7F;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_val = 0; m_left = 0; m_done = 0; m_seg = 7'h7F; m_seg_nb = 7'h7F;
    end else begin
      m_seg    = enc(m_val, int'(di), 1'b1);
      m_seg_nb = enc(m_val, int'(di), 1'b0);
      m_done   = 0;
      if (m_left == 0) begin
        if (load) begin
          m_target = (int'(score) > 9999) ? 9999 : int'(score);
          m_left   = SW + 1;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_val  = m_target;
          m_done = 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("busy", 16'(busy), 16'(m_left > 0));
    chk("done", 16'(done), 16'(m_done));
    chk("bcd", bcd, to_bcd(m_val));
    chk("seg", 16'(seg), 16'(m_seg));
    chk("dp", 16'(dp), 16'd1);
    chk("bcd_nb", bcd_nb, to_bcd(m_val));
    chk("seg_nb", 16'(seg_nb), 16'(m_seg_nb));
    chk("done_nb", 16'(done_nb), 16'(done));
    chk("busy_nb", 16'(busy_nb), 16'(busy));
    chk("dp_nb", 16'(dp_nb), 16'd1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int v);
    score = SW'(v);
    load  = 1'b1;
    tick(1);
    load  = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      cyc++;
      if (done) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL wait_done: got no done after %0d cycles expected done", cyc);
  endtask

  task automatic seg_digit(input string name, input int d, input logic [6:0] e, input logic [6:0] e_nb);
    di = 2'(d);
    tick(1);
    chk(name, 16'(seg), 16'(e));
    chk({name, "_nb"}, 16'(seg_nb), 16'(e_nb));
  endtask

  int cyc;
  int dones;

  initial begin
    #2 rst = 1'b0;
    tick(2);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_bcd", bcd, 16'h0000);
    chk("rst_seg", 16'(seg), 16'h7F);
    chk("rst_dp", 16'(dp), 16'd1);
    rst = 1'b1;

    seg_digit("zero_d0", 0, 7'h40, 7'h40);
    seg_digit("zero_d3", 3, 7'h7F, 7'h40);

    do_load(1234);
    chk("busy_after_load", 16'(busy), 16'd1);
    wait_done(cyc);
    chk("lat_1234", 16'(cyc), 16'd15);
    chk("bcd_1234", bcd, 16'h1234);
    seg_digit("d3_1234", 3, 7'h79, 7'h79);
    seg_digit("d2_1234", 2, 7'h24, 7'h24);
    seg_digit("d1_1234", 1, 7'h30, 7'h30);
    seg_digit("d0_1234", 0, 7'h19, 7'h19);

    do_load(16383);
    wait_done(cyc);
    chk("bcd_sat", bcd, 16'h9999);
    for (int d = 3; d >= 0; d--) seg_digit("seg_sat", d, 7'h10, 7'h10);

    do_load(7);
    wait_done(cyc);
    chk("bcd_7", bcd, 16'h0007);
    for (int d = 3; d >= 1; d--) seg_digit("blank_7", d, 7'h7F, 7'h40);
    seg_digit("d0_7", 0, 7'h78, 7'h78);

    // Second request while busy must be dropped.
    do_load(1234);
    tick(4);
    do_load(42);
    wait_done(cyc);
    chk("lat_ignored", 16'(cyc), 16'd10);
    chk("bcd_ignored", bcd, 16'h1234);
    do_load(42);
    wait_done(cyc);
    chk("lat_b2b", 16'(cyc), 16'd15);
    chk("bcd_42", bcd, 16'h0042);

    // Abort mid-conversion.
    do_load(9999);
    tick(7);
    rst = 1'b0;
    #1;
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_done", 16'(done), 16'd0);
    chk("abort_bcd", bcd, 16'h0000);
    tick(2);
    rst = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (done) dones++;
    end
    chk("abort_no_done", 16'(dones), 16'd0);
    chk("abort_bcd_hold", bcd, 16'h0000);
    do_load(56);
    wait_done(cyc);
    chk("lat_56", 16'(cyc), 16'd15);
    chk("bcd_56", bcd, 16'h0056);
    seg_digit("d1_56", 1, 7'h12, 7'h12);
    seg_digit("d2_56", 2, 7'h7F, 7'h40);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
